serial_rx_framer: RTL and testbench
===================================

// Module: serial_rx_framer
// PURPOSE
//  Frame controller sitting after the serial RX byte receiver. Sequences
//  received bytes into framed packets: SYNC, LEN, LEN payload bytes, CHK.
//  Buffers the payload, checks length and checksum, and presents a good
//  frame to a consumer through a valid/ack handshake and a random-read port.
//  Reports bad, truncated and dropped input.
// PARAMETERS
//  SYNC_BYTE  8'hA5  start-of-frame marker
//  MAX_LEN    16     max payload bytes; must equal 2**ADDR_W
//  ADDR_W     4      payload buffer address width
// PORTS
//  clk            in   1       system clock; single clock domain
//  rst_n          in   1       asynchronous reset, active-low
//  rx_data_ready  in   1       1-clk strobe: rx_data is a valid byte
//  rx_data        in   8       received byte
//  rx_endofpacket in   1       1-clk strobe: line gap detected
//  frame_valid    out  1       good frame held in buffer
//  frame_len      out  8       payload length of the held frame (1..MAX_LEN)
//  frame_ack      in   1       consumer releases the frame
//  rd_addr        in   ADDR_W  payload read address
//  rd_data        out  8       payload byte; registered, 1 clk after rd_addr
//  frame_err      out  1       1-clk pulse: frame rejected
//  err_code       out  2       1=bad LEN, 2=bad CHK, 3=truncated; held until next err
//  frame_drop     out  1       1-clk pulse: byte discarded while frame held
// BEHAVIOUR
//  Reset: state IDLE; frame_valid, frame_len, rd_data, frame_err, err_code,
//   frame_drop all 0. Buffer contents undefined. Reset mid-frame discards it.
//  All state changes occur only on rx_data_ready, rx_endofpacket or frame_ack.
//  FSM:
//   IDLE: byte==SYNC_BYTE -> LEN. Other bytes ignored; endofpacket ignored.
//   LEN : byte 0 or >MAX_LEN -> IDLE, frame_err, err_code=1.
//         Otherwise latch len, sum=byte, idx=0 -> DATA.
//   DATA: write buf[idx]=byte, sum+=byte (mod 256), idx++. After byte
//         number len -> CHK. A SYNC_BYTE value here is payload, not a resync.
//   CHK : byte==sum -> HOLD; frame_valid=1 and frame_len=len, both on the
//         clk after the strobe. Else -> IDLE, frame_err, err_code=2.
//   HOLD: frame_valid stays high until frame_ack. Every rx_data_ready ->
//         frame_drop pulse, byte ignored. frame_ack -> frame_valid=0 on the
//         next clk, state IDLE.
//  Truncation: rx_endofpacket in LEN/DATA/CHK -> IDLE, frame_err,
//   err_code=3. If rx_data_ready is in the same clk, endofpacket wins and
//   the byte is discarded.
//  HOLD: frame_ack with rx_data_ready in the same clk -> byte dropped
//   (frame_drop pulses); the framer re-arms next clk. frame_ack outside
//   HOLD is ignored.
//  Latency: frame_err, frame_drop and frame_valid rise exactly 1 clk after
//   the causing strobe.
//  Sum is 8 bits and wraps. The buffer is written only in DATA; it is
//   never written in HOLD, so the held payload is stable.
//  rd_data = buf[rd_addr] registered every clk. Addresses >= frame_len
//   return stale data; this is legal but undefined.
// TESTING
//  A5 03 11 22 33 69 -> frame_valid 1 clk after CHK strobe, frame_len=3;
//   rd_addr 0,1,2 -> 11,22,33; frame_ack -> frame_valid 0 next clk.
//  A5 02 10 20 00 -> frame_err, err_code=2, no frame_valid; then
//   A5 01 7F 80 -> valid, frame_len=1.
//  A5 00, and separately A5 11 (MAX_LEN=16) -> frame_err, err_code=1; the
//   next good frame is accepted.
//  A5 04 01 02 then rx_endofpacket -> frame_err, err_code=3, IDLE.
//   endofpacket coincident with a DATA byte -> same result.
//  Frame held, send 3 bytes before ack -> 3 frame_drop pulses; buffer and
//   frame_len unchanged. Ack coincident with a byte -> drop, then re-arm.
//  A5 10 + 16x FF + wrapped CHK 00 -> frame_len=16; all 16 addresses read FF.
//   Assert rst_n low mid-DATA -> all outputs 0; next frame good.

Source files
------------

// File: rtl/serial_rx_framer_if.sv
// Byte-stream input, frame handshake and payload read port of the RX framer.
// The framer takes the slave modport; the byte source and frame consumer take master.
interface serial_rx_framer_if #(
  parameter int ADDR_W = 4
) ();
  logic              rx_data_ready;
  logic [7:0]        rx_data;
  logic              rx_endofpacket;
  logic              frame_valid;
  logic [7:0]        frame_len;
  logic              frame_ack;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              frame_err;
  logic [1:0]        err_code;
  logic              frame_drop;

  modport master (
    output rx_data_ready, rx_data, rx_endofpacket, frame_ack, rd_addr,
    input  frame_valid, frame_len, rd_data, frame_err, err_code, frame_drop
  );

  modport slave (
    input  rx_data_ready, rx_data, rx_endofpacket, frame_ack, rd_addr,
    output frame_valid, frame_len, rd_data, frame_err, err_code, frame_drop
  );
endinterface

// File: rtl/serial_rx_framer.sv
// Frames a received byte stream as SYNC, LEN, payload, CHK; holds a good
// payload for the consumer and flags bad, truncated and dropped input.
module serial_rx_framer #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         MAX_LEN   = 16,
  parameter int         ADDR_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_rx_framer_if.slave bus
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [1:0] ERR_LEN   = 2'd1;
  localparam logic [1:0] ERR_CHK   = 2'd2;
  localparam logic [1:0] ERR_TRUNC = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CHK,
    S_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        frame_valid_q, frame_valid_d;
  logic [7:0]  frame_len_q, frame_len_d;
  logic        frame_err_q, frame_err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        frame_drop_q, frame_drop_d;
  logic [7:0]  rd_data_q;
  logic        wr_en;

  logic [7:0]  buf_q [MAX_LEN];

  // Running checksum covers LEN plus every payload byte, modulo 256.
  function automatic logic [7:0] sum_wrap(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    sum_d         = sum_q;
    cnt_d         = cnt_q;
    frame_valid_d = frame_valid_q;
    frame_len_d   = frame_len_q;
    frame_err_d   = 1'b0;
    err_code_d    = err_code_q;
    frame_drop_d  = 1'b0;
    wr_en         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.rx_data_ready && bus.rx_data == SYNC_BYTE) begin
          state_d = S_LEN;
        end
      end

      S_LEN: begin
        if (bus.rx_endofpacket) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
          err_code_d  = ERR_TRUNC;
        end else if (bus.rx_data_ready) begin
          if (bus.rx_data == 8'd0 || bus.rx_data > MAX_LEN_B) begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
          end else begin
            len_d   = bus.rx_data;
            sum_d   = bus.rx_data;
            cnt_d   = 8'd0;
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (bus.rx_endofpacket) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
          err_code_d  = ERR_TRUNC;
        end else if (bus.rx_data_ready) begin
          wr_en = 1'b1;
          sum_d = sum_wrap(sum_q, bus.rx_data);
          cnt_d = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == len_q) begin
            state_d = S_CHK;
          end
        end
      end

      S_CHK: begin
        if (bus.rx_endofpacket) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
          err_code_d  = ERR_TRUNC;
        end else if (bus.rx_data_ready) begin
          if (bus.rx_data == sum_q) begin
            state_d       = S_HOLD;
            frame_valid_d = 1'b1;
            frame_len_d   = len_q;
          end else begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
            err_code_d  = ERR_CHK;
          end
        end
      end

      S_HOLD: begin
        // Nothing reaches the buffer while held; incoming bytes are only counted as drops.
        if (bus.rx_data_ready) begin
          frame_drop_d = 1'b1;
        end
        if (bus.frame_ack) begin
          frame_valid_d = 1'b0;
          state_d       = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      len_q         <= 8'd0;
      sum_q         <= 8'd0;
      cnt_q         <= 8'd0;
      frame_valid_q <= 1'b0;
      frame_len_q   <= 8'd0;
      frame_err_q   <= 1'b0;
      err_code_q    <= 2'd0;
      frame_drop_q  <= 1'b0;
      rd_data_q     <= 8'd0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      sum_q         <= sum_d;
      cnt_q         <= cnt_d;
      frame_valid_q <= frame_valid_d;
      frame_len_q   <= frame_len_d;
      frame_err_q   <= frame_err_d;
      err_code_q    <= err_code_d;
      frame_drop_q  <= frame_drop_d;
      rd_data_q     <= buf_q[bus.rd_addr];
    end
  end

  // Payload storage carries no reset; its contents are meaningful only while a frame is held.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_q[cnt_q[ADDR_W-1:0]] <= bus.rx_data;
    end
  end

  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_len   = frame_len_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.err_code    = err_code_q;
  assign bus.frame_drop  = frame_drop_q;

endmodule

// File: tb/tb_serial_rx_framer.sv
// Randomized and directed stimulus for serial_rx_framer, checked against a
// frame-level reference model that collects bytes and judges whole frames.
module tb_serial_rx_framer;

  localparam logic [7:0] SYNC = 8'hA5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_rx_framer_if #(.ADDR_W(4)) bus ();

  serial_rx_framer #(.SYNC_BYTE(8'hA5), .MAX_LEN(16), .ADDR_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: bytes after SYNC are gathered and judged as a frame.
  logic       m_in;
  logic       m_hold;
  logic [7:0] m_q[$];
  logic [1:0] m_code;
  logic [7:0] m_len;
  logic [7:0] m_pay[16];
  logic       e_err, e_drop;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_in = 0; m_hold = 0; m_code = 0; m_len = 0; m_q.delete();
  endtask

  task automatic model_step(input logic rdy, input logic [7:0] d, input logic eop, input logic ack);
    int sum;
    int n;
    e_err = 0; e_drop = 0;
    if (m_hold) begin
      if (rdy) e_drop = 1;
      if (ack) m_hold = 0;
    end else if (m_in) begin
      if (eop) begin
        m_in = 0; e_err = 1; m_code = 3;
      end else if (rdy) begin
        m_q.push_back(d);
        n = m_q.size();
        if (n == 1 && (d == 0 || d > 16)) begin
          m_in = 0; e_err = 1; m_code = 1;
        end else if (n >= 2 && n == int'(m_q[0]) + 2) begin
          sum = 0;
          for (int i = 0; i < n - 1; i++) sum += int'(m_q[i]);
          if ((sum % 256) == int'(d)) begin
            m_hold = 1;
            m_len  = m_q[0];
            for (int i = 0; i < int'(m_q[0]); i++) m_pay[i] = m_q[i+1];
          end else begin
            e_err = 1; m_code = 2;
          end
          m_in = 0;
        end
      end
    end else if (rdy && d == SYNC) begin
      m_in = 1;
      m_q.delete();
    end
  endtask

  // One clock: drive at negedge, sample 1 time unit after the active edge.
  task automatic step(input logic rdy, input logic [7:0] d, input logic eop,
                      input logic ack, input logic [3:0] ra, input logic do_rd);
    @(negedge clk);
    bus.rx_data_ready  = rdy;
    bus.rx_data        = d;
    bus.rx_endofpacket = eop;
    bus.frame_ack      = ack;
    bus.rd_addr        = ra;
    @(posedge clk);
    #1;
    model_step(rdy, d, eop, ack);
    chk("frame_err", bus.frame_err, e_err);
    chk("frame_drop", bus.frame_drop, e_drop);
    chk("frame_valid", bus.frame_valid, m_hold);
    chk("err_code", bus.err_code, m_code);
    if (m_hold) chk("frame_len", bus.frame_len, m_len);
    if (do_rd) chk("rd_data", bus.rd_data, m_pay[ra]);
    bus.rx_data_ready  = 0;
    bus.rx_endofpacket = 0;
    bus.frame_ack      = 0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    step(1, d, 0, 0, 0, 0);
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) step(0, 8'h00, 0, 0, 0, 0);
  endtask

  task automatic send_frame(input logic [7:0] fr[$]);
    foreach (fr[i]) begin
      send_byte(fr[i]);
      gap();
    end
  endtask

  task automatic read_all();
    for (int a = 0; a < int'(m_len); a++) step(0, 8'h00, 0, 0, 4'(a), 1);
  endtask

  task automatic ack_frame();
    step(0, 8'h00, 0, 1, 0, 0);
  endtask

  task automatic reset_check(input string tag);
    @(negedge clk);
    rst_n = 0;
    #1;
    model_clear();
    chk({tag, "_valid"}, bus.frame_valid, 0);
    chk({tag, "_len"}, bus.frame_len, 0);
    chk({tag, "_rd"}, bus.rd_data, 0);
    chk({tag, "_err"}, bus.frame_err, 0);
    chk({tag, "_code"}, bus.err_code, 0);
    chk({tag, "_drop"}, bus.frame_drop, 0);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    logic [7:0] fr[$];
    logic [7:0] ck;
    int kind, len, pos;

    bus.rx_data_ready = 0; bus.rx_data = 0; bus.rx_endofpacket = 0;
    bus.frame_ack = 0; bus.rd_addr = 0;
    rst_n = 1;
    model_clear();
    reset_check("rst0");

    // Basic good frame
    send_frame('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69});
    chk("t1_valid", bus.frame_valid, 1);
    chk("t1_len", bus.frame_len, 3);
    step(0, 0, 0, 0, 4'd0, 1); chk("t1_rd0", bus.rd_data, 8'h11);
    step(0, 0, 0, 0, 4'd1, 1); chk("t1_rd1", bus.rd_data, 8'h22);
    step(0, 0, 0, 0, 4'd2, 1); chk("t1_rd2", bus.rd_data, 8'h33);
    ack_frame();
    chk("t1_ack", bus.frame_valid, 0);

    // Bad checksum, then recovery
    send_frame('{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00});
    chk("t2_code", bus.err_code, 2);
    send_frame('{8'hA5, 8'h01, 8'h7F, 8'h80});
    chk("t2_len", bus.frame_len, 1);
    ack_frame();

    // Length out of range
    send_frame('{8'hA5, 8'h00});
    chk("t3_code0", bus.err_code, 1);
    send_frame('{8'hA5, 8'h11});
    chk("t3_code17", bus.err_code, 1);
    send_frame('{8'hA5, 8'h01, 8'h7F, 8'h80});
    chk("t3_recover", bus.frame_valid, 1);
    ack_frame();

    // Truncation, separate and coincident with a data byte
    send_frame('{8'hA5, 8'h04, 8'h01, 8'h02});
    step(0, 0, 1, 0, 0, 0);
    chk("t4_code", bus.err_code, 3);
    send_frame('{8'hA5, 8'h01, 8'h7F, 8'h80});
    ack_frame();
    send_frame('{8'hA5, 8'h04, 8'h01});
    step(1, 8'h02, 1, 0, 0, 0);
    chk("t4b_code", bus.err_code, 3);

    // Drops while held, ack coincident with a byte, re-arm
    send_frame('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69});
    repeat (3) send_byte(8'h5A);
    chk("t5_len", bus.frame_len, 3);
    read_all();
    step(1, 8'h55, 0, 1, 0, 0);
    chk("t5_ackdrop", bus.frame_drop, 1);
    send_frame('{8'hA5, 8'h01, 8'h7F, 8'h80});
    chk("t5_rearm", bus.frame_valid, 1);
    ack_frame();

    // Maximum length with wrapped checksum
    fr.delete();
    fr.push_back(8'hA5); fr.push_back(8'h10);
    repeat (16) fr.push_back(8'hFF);
    fr.push_back(8'h00);
    send_frame(fr);
    chk("t6_len", bus.frame_len, 16);
    read_all();
    ack_frame();

    // Reset mid-DATA
    send_frame('{8'hA5, 8'h05, 8'h01, 8'h02});
    reset_check("rst1");
    send_frame('{8'hA5, 8'h01, 8'h7F, 8'h80});
    chk("t7_after_rst", bus.frame_valid, 1);
    ack_frame();

    // Randomized frames
    for (int it = 0; it < 150; it++) begin
      kind = $urandom_range(0, 5);
      len  = $urandom_range(1, 16);
      if (kind == 1) len = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(17, 255);
      fr.delete();
      fr.push_back(SYNC);
      fr.push_back(8'(len));
      ck = 8'(len);
      if (kind != 1) begin
        for (int i = 0; i < len; i++) begin
          fr.push_back(8'($urandom_range(0, 255)));
          ck = ck + fr[fr.size()-1];
        end
        if (kind == 2) ck = ck ^ 8'($urandom_range(1, 255));
        fr.push_back(ck);
      end
      if (kind == 3) begin
        pos = $urandom_range(1, fr.size() - 1);
        for (int i = 0; i < pos; i++) send_byte(fr[i]);
        step(($urandom_range(0, 1) != 0), fr[pos], 1, 0, 0, 0);
      end else if (kind == 4) begin
        repeat ($urandom_range(1, 4))
          step(1, 8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0), 0, 0, 0);
      end else begin
        send_frame(fr);
      end
      if (m_hold) begin
        repeat ($urandom_range(0, 3)) send_byte(8'($urandom_range(0, 255)));
        repeat (4) step(0, 0, 0, 0, 4'($urandom_range(0, int'(m_len) - 1)), 1);
        step(($urandom_range(0, 1) != 0), 8'($urandom_range(0, 255)), 0, 1, 0, 0);
      end else if ($urandom_range(0, 3) == 0) begin
        step(0, 0, 0, 1, 0, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
